ram_responder: RTL and testbench
================================

# ram_responder

Memory-side end of the CPU data-memory port. It holds the data memory array and captures writes presented on `port_write`/`port_addr`/`port_value`. It drives read data back onto the shared tri-state `port_value` bus, with enforced bus turnaround after every write. After reset it sweeps the whole array to zero before accepting traffic. It sits at top level opposite the CPU's port interface, connected wire-for-wire to the same three port signals.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: word width.
- `ADDR_WIDTH`, default `` `DATA_DEPTH ``: address width; the array holds 2^ADDR_WIDTH words.
- `TURN_CYCLES`, default 1: Hi-Z cycles after a write or after the clear sweep; legal range 1..7.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `port_write` input, 1 bit: CPU write strobe; while high the CPU drives `port_value`.
- `port_addr` input, ADDR_WIDTH bits: word address.
- `port_value` inout, DATA_WIDTH bits: shared data bus.
- `ready` output, 1 bit: high once the clear sweep is done.
- `wr_err` output, 1 bit: sticky; set when a write arrives while `ready` is low.

## Operation
- **States**
  - CLEAR: writes zero to address `clr_cnt` each cycle. `clr_cnt` counts 0 to 2^ADDR_WIDTH-1. After the last address, go to TURN.
  - TURN: bus is Hi-Z. `turn_cnt` counts down from TURN_CYCLES-1. At 0, go to DRIVE.
  - DRIVE: the block drives read data.
  - Any state with `rst` high goes to CLEAR with `clr_cnt`=0.
- **Output enable:** `oe = (state==DRIVE) && !port_write`. It is combinational, so the responder releases the bus in the same cycle the CPU starts driving. The block never drives while `port_write` is high.
- **Read:** asynchronous. While `oe` is high, `port_value = mem[port_addr]`. Otherwise `port_value` is all-Z.
- **Write:** at a rising edge with `port_write`=1 and state in TURN or DRIVE, `mem[port_addr] <= port_value`. Writes during TURN are legal: the bus is already released.
- **Turnaround:** a write edge in DRIVE moves the state to TURN and reloads `turn_cnt`. A write edge in TURN reloads `turn_cnt` only, so back-to-back writes keep the bus Hi-Z.
- **Write in CLEAR:** memory is not modified, `wr_err` is set, and the sweep continues unaffected. `wr_err` clears only on `rst`.
- **Read-after-write:** the data written at edge N is visible on the bus once DRIVE is re-entered, TURN_CYCLES cycles later.
- **Address width:** `port_addr` is used at full width with no masking. The `clr_cnt` wrap from all-ones is the exit condition and is never used as an address.

## Timing
- **Reset values:** state=CLEAR, `clr_cnt`=0, `ready`=0, `wr_err`=0, `port_value`=Z.
- **Clear duration:** 2^ADDR_WIDTH cycles after `rst` is released, then TURN_CYCLES cycles of TURN.
- **`ready`:** rises on the first edge out of CLEAR, i.e. entry to TURN. It is registered and never falls except on `rst`.
- **Read latency:** 0 cycles, combinational from `port_addr` to `port_value` within DRIVE.
- **Write latency:** captured on the edge where `port_write`=1. No back-pressure exists.
- **Reset mid-operation:** reset during CLEAR restarts the sweep from address 0. Reset during DRIVE releases the bus the next cycle and re-clears the array.

## Structure
- Port widths come from the shared `defs.v` macros (`DATA_WIDTH`, `DATA_DEPTH`).
- The state encoding (`RR_CLEAR`, `RR_TURN`, `RR_DRIVE`) is defined as `` `define `` constants in `defs.v` alongside them.
- One sub-module, `ram_array`: the 2^ADDR_WIDTH x DATA_WIDTH storage with one async read port and one sync write port (we, waddr, wdata).
- The write port is muxed between the clear sweep and the CPU write. The FSM, counters and tri-state driver stay in `ram_responder`.

## Test plan
Bench configuration: ADDR_WIDTH=4, DATA_WIDTH=8, TURN_CYCLES=1.
1. **Reset and clear:** release `rst` at cycle 0. `ready` must be 0 for 16 cycles, then 1. In DRIVE, reading addresses 0..15 returns 8'h00 for each.
2. **Write then read:** write 8'hA5 to address 3. The next cycle the bus must be Z (turnaround). On the following cycle, `port_addr`=3 must show 8'hA5.
3. **Back-to-back writes:** write 8'h11/8'h22/8'h33 to addresses 0/1/2 on consecutive cycles. The responder must not drive during any of those cycles or the one after. Readback must give 11/22/33.
4. **Contention check:** assert `port_write` in DRIVE. The responder must be Z in that same cycle; the bench must see no X on `port_value`.
5. **Early write:** write 8'hFF to address 5 during CLEAR. `wr_err` must go to 1 and stay 1. After `ready`, address 5 must read 8'h00.
6. **Mid-sweep reset:** pulse `rst` at clear cycle 8 after writing, then wait. `ready` must stay 0 for a fresh 16 cycles, and `wr_err` must read 0.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared definitions for the data-memory responder: default widths and FSM states.
package ram_responder_pkg;

  localparam int unsigned RR_DATA_WIDTH = 8;
  localparam int unsigned RR_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    RR_CLEAR = 2'd0,
    RR_TURN  = 2'd1,
    RR_DRIVE = 2'd2
  } rr_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// CPU data-memory port control signals plus responder status.
//   port_write : CPU write strobe (CPU drives the data bus while high)
//   port_addr  : word address
//   ready      : clear sweep finished
//   wr_err     : sticky, write seen before ready
// The shared data bus port_value is a module-level inout net.
interface ram_responder_if
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RR_ADDR_WIDTH
);

  logic                  port_write;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic                  ready;
  logic                  wr_err;

  modport master (
    output port_write,
    output port_addr,
    input  ready,
    input  wr_err
  );

  modport slave (
    input  port_write,
    input  port_addr,
    output ready,
    output wr_err
  );

endinterface

// File: rtl/ram_responder_ram_array.sv
// 2^ADDR_WIDTH x DATA_WIDTH storage: one asynchronous read port, one synchronous write port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the CPU data-memory port.
// Sweeps the array to zero after reset, then captures CPU writes and drives
// asynchronous read data onto the shared tri-state bus, with Hi-Z turnaround
// after every write and after the sweep.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : port_write / port_addr in, ready / wr_err out
//   port_value : shared bidirectional data bus
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = RR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = RR_ADDR_WIDTH,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_responder_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] port_value
);

  localparam logic [2:0] TURN_LOAD = 3'(TURN_CYCLES - 1);

  rr_state_t             state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [2:0]            turn_cnt;
  logic                  ready_q;
  logic                  wr_err_q;

  logic                  oe;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RR_CLEAR;
      clr_cnt  <= '0;
      turn_cnt <= '0;
      ready_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      case (state)
        RR_CLEAR: begin
          if (bus.port_write) begin
            wr_err_q <= 1'b1;
          end
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state    <= RR_TURN;
            turn_cnt <= TURN_LOAD;
            ready_q  <= 1'b1;
          end
        end
        RR_TURN: begin
          // A write here only restarts the countdown, keeping the bus released.
          if (bus.port_write) begin
            turn_cnt <= TURN_LOAD;
          end else if (turn_cnt == '0) begin
            state <= RR_DRIVE;
          end else begin
            turn_cnt <= turn_cnt - 3'd1;
          end
        end
        RR_DRIVE: begin
          if (bus.port_write) begin
            state    <= RR_TURN;
            turn_cnt <= TURN_LOAD;
          end
        end
        default: begin
          state <= RR_CLEAR;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and CPU writes; CPU writes
  // during CLEAR are dropped because the sweep owns the port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.port_addr;
    mem_wdata = port_value;
    if (state == RR_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (bus.port_write) begin
      mem_we = 1'b1;
    end
  end

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.port_addr),
    .rdata (mem_rdata)
  );

  // Combinational enable so the bus is released in the same cycle the CPU starts driving.
  assign oe         = (state == RR_DRIVE) && !bus.port_write;
  assign port_value = oe ? mem_rdata : 'z;

  assign bus.ready  = ready_q;
  assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  localparam int KZ = 0;  // bus expected released (reads as pulled-up all-ones)
  localparam int KD = 1;  // bus expected to carry a specific value

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] val;
    logic       rdy;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       tb_wr_en;
  logic [7:0] tb_data;
  wire  [7:0] port_value;

  int checks;
  int errors;
  exp_t sb[$];

  ram_responder_if #(.ADDR_WIDTH(4)) bus ();

  assign port_value = tb_wr_en ? tb_data : 'z;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (port_value[i]);
  end

  ram_responder #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .TURN_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .port_value (port_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input string nm, input logic r, input logic w,
                      input logic [3:0] a, input logic [7:0] d,
                      input logic e_rdy, input logic e_err,
                      input int kind, input logic [7:0] ev);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.port_write = w;
    bus.port_addr  = a;
    tb_wr_en       = w;
    tb_data        = d;
    e.name = nm;
    e.kind = kind;
    e.val  = ev;
    e.rdy  = e_rdy;
    e.err  = e_err;
    sb.push_back(e);
  endtask

  // Monitor: compares what the DUT presents mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.ready !== e.rdy) begin
          errors++;
          $display("FAIL %s ready: got %b want %b", e.name, bus.ready, e.rdy);
        end
        checks++;
        if (bus.wr_err !== e.err) begin
          errors++;
          $display("FAIL %s wr_err: got %b want %b", e.name, bus.wr_err, e.err);
        end
        want = (e.kind == KZ) ? 8'hFF : e.val;
        checks++;
        if (port_value !== want) begin
          errors++;
          $display("FAIL %s port_value: got %h want %h (%s)", e.name, port_value, want,
                   (e.kind == KZ) ? "released" : "driven");
        end
      end
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.port_write = 1'b0;
    bus.port_addr  = '0;
    tb_wr_en       = 1'b0;
    tb_data        = '0;

    // Reset state
    repeat (2) step("reset", 1, 0, 4'd0, 8'h00, 0, 0, KZ, 8'h00);

    // Sweep with an early write to address 5 at clear cycle 3
    for (int c = 0; c < 16; c++) begin
      if (c == 3) step("early_wr", 0, 1, 4'd5, 8'hFF, 0, 0, KD, 8'hFF);
      else        step("clear", 0, 0, 4'd0, 8'h00, 0, logic'(c >= 4), KZ, 8'h00);
    end
    step("turn0", 0, 0, 4'd0, 8'h00, 1, 1, KZ, 8'h00);
    for (int a = 0; a < 16; a++) begin
      step("sweep_rd", 0, 0, 4'(a), 8'h00, 1, 1, KD, 8'h00);
    end

    // Write then read
    step("wr_a5",   0, 1, 4'd3, 8'hA5, 1, 1, KD, 8'hA5);
    step("turn_a5", 0, 0, 4'd3, 8'h00, 1, 1, KZ, 8'h00);
    step("rd_a5",   0, 0, 4'd3, 8'h00, 1, 1, KD, 8'hA5);

    // Back-to-back writes keep the bus released
    step("b2b_wr0", 0, 1, 4'd0, 8'h11, 1, 1, KD, 8'h11);
    step("b2b_wr1", 0, 1, 4'd1, 8'h22, 1, 1, KD, 8'h22);
    step("b2b_wr2", 0, 1, 4'd2, 8'h33, 1, 1, KD, 8'h33);
    step("b2b_turn", 0, 0, 4'd0, 8'h00, 1, 1, KZ, 8'h00);
    step("b2b_rd0", 0, 0, 4'd0, 8'h00, 1, 1, KD, 8'h11);
    step("b2b_rd1", 0, 0, 4'd1, 8'h00, 1, 1, KD, 8'h22);
    step("b2b_rd2", 0, 0, 4'd2, 8'h00, 1, 1, KD, 8'h33);

    // Contention: write in DRIVE over a location holding different bits
    step("contend_wr",   0, 1, 4'd1, 8'h44, 1, 1, KD, 8'h44);
    step("contend_turn", 0, 0, 4'd1, 8'h00, 1, 1, KZ, 8'h00);
    step("contend_rd",   0, 0, 4'd1, 8'h00, 1, 1, KD, 8'h44);
    step("rd_a5_again",  0, 0, 4'd3, 8'h00, 1, 1, KD, 8'hA5);

    // Reset during DRIVE: bus still driven this cycle, released next
    step("rst_in_drive", 1, 0, 4'd3, 8'h00, 1, 1, KD, 8'hA5);
    for (int c = 0; c <= 8; c++) begin
      if (c == 8)      step("mid_rst", 1, 0, 4'd0, 8'h00, 0, 1, KZ, 8'h00);
      else if (c == 2) step("early_wr2", 0, 1, 4'd7, 8'hFF, 0, 0, KD, 8'hFF);
      else             step("clear2", 0, 0, 4'd0, 8'h00, 0, logic'(c >= 3), KZ, 8'h00);
    end

    // Fresh sweep after mid-sweep reset
    for (int c = 0; c < 16; c++) begin
      step("fresh", 0, 0, 4'd0, 8'h00, 0, 0, KZ, 8'h00);
    end
    step("turn2",   0, 0, 4'd0, 8'h00, 1, 0, KZ, 8'h00);
    step("reclr_3", 0, 0, 4'd3, 8'h00, 1, 0, KD, 8'h00);
    step("reclr_1", 0, 0, 4'd1, 8'h00, 1, 0, KD, 8'h00);
    step("reclr_7", 0, 0, 4'd7, 8'h00, 1, 0, KD, 8'h00);
    step("reclr_0", 0, 0, 4'd0, 8'h00, 1, 0, KD, 8'h00);

    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
